// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: branch codes, fetch FSM encodings and
// the branch-decision helper used by the next-PC logic.
package fetch_unit_pkg;

   localparam logic [1:0] BR_NONE = 2'b00;
   localparam logic [1:0] BR_EQ   = 2'b01;
   localparam logic [1:0] BR_NE   = 2'b10;
   localparam logic [1:0] BR_RSVD = 2'b11;

   localparam logic [1:0] ST_BOOT  = 2'b00;
   localparam logic [1:0] ST_FETCH = 2'b01;
   localparam logic [1:0] ST_EXEC  = 2'b10;

   // The reserved code behaves like "no branch" so a bad decode cannot redirect the PC.
   function automatic logic branch_taken(input logic [1:0] br, input logic zero);
      logic t;
      case (br)
         BR_NONE: t = 1'b0;
         BR_EQ:   t = zero;
         BR_NE:   t = ~zero;
         BR_RSVD: t = 1'b0;
         default: t = 1'b0;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC candidates for the retiring instruction: sequential pc+4, the
// PC-relative branch target, and whether the branch is taken.
module pc_next_calc
   import fetch_unit_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic [ADDR_W-1:0] pc,
   input  logic [15:0]       imm16,
   input  logic [1:0]        Branch,
   input  logic              Zero,
   output logic [ADDR_W-1:0] pc4,
   output logic [ADDR_W-1:0] target,
   output logic              taken
);

   logic [ADDR_W-1:0] offset;

   // Word offset sign-extended to the full address width; all sums wrap.
   assign offset = {{(ADDR_W-16){imm16[15]}}, imm16} << 2'd2;
   assign pc4    = pc + {{(ADDR_W-3){1'b0}}, 3'b100};
   assign target = pc4 + offset;
   assign taken  = branch_taken(Branch, Zero);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC and instruction registers, imem req/ack
// handshake, and next-PC resolution on retire.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset_n,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   input  logic              stall,
   input  logic [1:0]        Branch,
   input  logic              Zero,
   output logic [ADDR_W-1:0] pc,
   output logic [31:0]       instr,
   output logic              instr_valid,
   output logic [5:0]        Op,
   output logic [5:0]        Func
);

   localparam logic [ADDR_W-1:0] BOOT_PC = {RESET_PC[ADDR_W-1:2], 2'b00};

   logic [1:0]        state;
   logic [ADDR_W-1:0] pc4;
   logic [ADDR_W-1:0] target;
   logic              taken;

   pc_next_calc #(.ADDR_W(ADDR_W)) u_pc_next (
      .pc     (pc),
      .imm16  (instr[15:0]),
      .Branch (Branch),
      .Zero   (Zero),
      .pc4    (pc4),
      .target (target),
      .taken  (taken)
   );

   // Fetch FSM with PC and instruction registers; PC stays word aligned by construction.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state       <= ST_BOOT;
         pc          <= BOOT_PC;
         instr       <= 32'h0000_0000;
         instr_valid <= 1'b0;
      end else begin
         case (state)
            ST_BOOT: begin
               state <= ST_FETCH;
            end
            ST_FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= ST_EXEC;
               end
            end
            ST_EXEC: begin
               if (!stall) begin
                  pc          <= taken ? target : pc4;
                  instr_valid <= 1'b0;
                  state       <= ST_FETCH;
               end
            end
            default: begin
               state       <= ST_BOOT;
               instr_valid <= 1'b0;
            end
         endcase
      end
   end

   // Request is decoded straight from the state register so reset drops it at once.
   assign imem_req  = (state == ST_FETCH);
   assign imem_addr = pc;
   assign Op        = instr[31:26];
   assign Func      = instr[5:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed + randomized bench for fetch_unit; next-PC expectations come from
// a plain-arithmetic model of the branch rules.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        stall;
   logic [1:0]  Branch;
   logic        Zero;
   logic [31:0] pc;
   logic [31:0] instr;
   logic        instr_valid;
   logic [5:0]  Op;
   logic [5:0]  Func;

   int          checks = 0;
   int          fails  = 0;
   logic [31:0] exp_pc;

   fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ack    (imem_ack),
      .imem_rdata  (imem_rdata),
      .stall       (stall),
      .Branch      (Branch),
      .Zero        (Zero),
      .pc          (pc),
      .instr       (instr),
      .instr_valid (instr_valid),
      .Op          (Op),
      .Func        (Func)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] model_next(input logic [31:0] p, input logic [31:0] w,
                                              input logic [1:0] br, input logic z);
      int off;
      bit tk;
      tk  = (br == 2'd1 && z) || (br == 2'd2 && !z);
      off = int'($signed(w[15:0]));
      return p + 32'd4 + (tk ? 32'(off * 4) : 32'd0);
   endfunction

   function automatic logic [31:0] br_word(input logic [15:0] imm);
      return {6'h04, 10'd0, imm};
   endfunction

   // Entered and left at a negedge with the DUT fetching at exp_pc.
   task automatic do_instr(input logic [31:0] w, input logic [1:0] br, input logic z,
                           input int waits, input int stalls);
      check("fetch_req", 32'(imem_req), 32'd1);
      check("fetch_addr", imem_addr, exp_pc);
      check("fetch_valid", 32'(instr_valid), 32'd0);
      for (int i = 0; i < waits; i++) begin
         imem_ack   = 1'b0;
         imem_rdata = $urandom;
         stall      = 1'($urandom);
         Branch     = 2'($urandom);
         Zero       = 1'($urandom);
         @(negedge clk);
         check("wait_req", 32'(imem_req), 32'd1);
         check("wait_addr", imem_addr, exp_pc);
      end
      imem_ack   = 1'b1;
      imem_rdata = w;
      stall      = 1'($urandom);
      @(negedge clk);
      imem_ack = 1'b0;
      check("latch_valid", 32'(instr_valid), 32'd1);
      check("latch_instr", instr, w);
      check("latch_op", 32'(Op), 32'(w[31:26]));
      check("latch_func", 32'(Func), 32'(w[5:0]));
      check("exec_req", 32'(imem_req), 32'd0);
      check("exec_pc", pc, exp_pc);
      for (int i = 0; i < stalls; i++) begin
         stall      = 1'b1;
         Branch     = 2'($urandom);
         Zero       = 1'($urandom);
         imem_ack   = 1'($urandom);
         imem_rdata = $urandom;
         @(negedge clk);
         check("stall_instr", instr, w);
         check("stall_pc", pc, exp_pc);
         check("stall_valid", 32'(instr_valid), 32'd1);
         check("stall_req", 32'(imem_req), 32'd0);
      end
      stall    = 1'b0;
      imem_ack = 1'b0;
      Branch   = br;
      Zero     = z;
      @(negedge clk);
      Branch = 2'd0;
      Zero   = 1'b0;
      exp_pc = model_next(exp_pc, w, br, z);
      check("next_req", 32'(imem_req), 32'd1);
      check("next_addr", imem_addr, exp_pc);
      check("next_pc", pc, exp_pc);
      check("next_valid", 32'(instr_valid), 32'd0);
   endtask

   task automatic do_reset();
      reset_n  = 1'b0;
      imem_ack = 1'b0;
      stall    = 1'b0;
      Branch   = 2'd0;
      Zero     = 1'b0;
      imem_rdata = 32'h0;
      @(negedge clk);
      @(negedge clk);
      check("rst_req", 32'(imem_req), 32'd0);
      check("rst_pc", pc, 32'h0);
      check("rst_instr", instr, 32'h0);
      check("rst_valid", 32'(instr_valid), 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      exp_pc = 32'h0;
      check("boot_to_fetch", 32'(imem_req), 32'd1);
   endtask

   initial begin
      exp_pc = 32'h0;
      do_reset();

      // zero-wait sequential fetches at 0, 4, 8, starting with an add
      do_instr(32'h0085_1020, 2'd0, 1'b0, 0, 0);
      check("seq_addr4", imem_addr, 32'h4);
      do_instr($urandom, 2'd0, 1'b1, 0, 0);
      check("seq_addr8", imem_addr, 32'h8);
      do_instr($urandom, 2'd3, 1'b1, 0, 0);
      check("seq_addrC", imem_addr, 32'hC);

      // jump to 0x40, then beq back/forward by the 0xFFFE offset
      do_instr(br_word(16'h000C), 2'd1, 1'b1, 0, 0);
      check("jump_40", imem_addr, 32'h40);
      do_instr(br_word(16'hFFFE), 2'd1, 1'b1, 0, 0);
      check("beq_taken", imem_addr, 32'h3C);
      do_instr(32'h0085_1020, 2'd0, 1'b0, 0, 0);
      do_instr(br_word(16'hFFFE), 2'd1, 1'b0, 0, 0);
      check("beq_not_taken", imem_addr, 32'h44);

      // bne and the reserved branch code at 0x100
      do_instr(br_word(16'h002E), 2'd1, 1'b1, 0, 0);
      check("jump_100", imem_addr, 32'h100);
      do_instr(br_word(16'h0003), 2'd2, 1'b0, 0, 0);
      check("bne_taken", imem_addr, 32'h110);
      do_instr(br_word(16'hFFFB), 2'd2, 1'b0, 0, 0);
      check("back_100", imem_addr, 32'h100);
      do_instr(br_word(16'h0003), 2'd3, 1'b1, 0, 0);
      check("rsvd_not_taken", imem_addr, 32'h104);

      // ack withheld 5 cycles, stall 3 cycles, exactly one retire
      do_instr(32'h0085_1020, 2'd0, 1'b0, 5, 3);
      check("wait_stall_retire", imem_addr, 32'h108);

      for (int n = 0; n < 40; n++) begin
         do_instr($urandom, 2'($urandom), 1'($urandom),
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
      end

      // reset asserted mid-fetch at 0x20
      do_reset();
      do_instr(br_word(16'h0007), 2'd1, 1'b1, 0, 0);
      check("jump_20", imem_addr, 32'h20);
      @(negedge clk);
      check("hold_20", imem_addr, 32'h20);
      #2;
      reset_n = 1'b0;
      #1;
      check("abort_req", 32'(imem_req), 32'd0);
      check("abort_valid", 32'(instr_valid), 32'd0);
      check("abort_pc", pc, 32'h0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      exp_pc = 32'h0;

      // wrap from 0xFFFFFFFC back to 0
      do_instr(br_word(16'hFFFE), 2'd1, 1'b1, 0, 0);
      check("to_top", imem_addr, 32'hFFFF_FFFC);
      do_instr(32'h0085_1020, 2'd0, 1'b0, 1, 1);
      check("wrap_zero", imem_addr, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
